// File: rtl/state_dump_unit.sv
// Handshaked result-extraction scanner: streams x0..x(NREGS-1), then NMEMW data-memory words.
// Optional trailing checksum word when DUMP_CHECKSUM_EN is defined.
module state_dump_unit #(
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NMEMW    = 8,
  parameter logic [31:0] MEM_BASE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [4:0]  reg_addr,
  input  logic [31:0] reg_rdata,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_kind,
  output logic [7:0]  out_index
);

  localparam logic [7:0] LAST_REG = 8'(NREGS - 1);
  localparam logic [7:0] LAST_MEM = 8'(NMEMW - 1);

  localparam logic [1:0] KIND_REG = 2'b00;
  localparam logic [1:0] KIND_MEM = 2'b01;
`ifdef DUMP_CHECKSUM_EN
  localparam logic [1:0] KIND_SUM = 2'b10;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REG,
    S_RD_MEM,
`ifdef DUMP_CHECKSUM_EN
    S_SUM,
`endif
    S_FIN
  } state_t;

  state_t      r_state;
  logic [7:0]  r_index;
  logic        r_busy;
  logic        r_done;
  logic [4:0]  r_reg_addr;
  logic [31:0] r_mem_addr;
  logic        r_out_valid;
  logic [31:0] r_out_data;
  logic [1:0]  r_out_kind;
  logic [7:0]  r_out_index;
`ifdef DUMP_CHECKSUM_EN
  logic [31:0] r_sum;
`endif

  // Output slot is free when empty or being drained this cycle.
  logic w_can_cap;
  assign w_can_cap = !r_out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_index     <= 8'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_reg_addr  <= 5'd0;
      r_mem_addr  <= MEM_BASE;
      r_out_valid <= 1'b0;
      r_out_data  <= 32'd0;
      r_out_kind  <= 2'b00;
      r_out_index <= 8'd0;
`ifdef DUMP_CHECKSUM_EN
      r_sum       <= 32'd0;
`endif
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_RD_REG;
            r_index    <= 8'd0;
            r_busy     <= 1'b1;
            r_reg_addr <= 5'd0;
            r_mem_addr <= MEM_BASE;
`ifdef DUMP_CHECKSUM_EN
            r_sum      <= 32'd0;
`endif
          end
        end

        S_RD_REG: begin
          if (w_can_cap) begin
            r_out_valid <= 1'b1;
            r_out_data  <= reg_rdata;
            r_out_kind  <= KIND_REG;
            r_out_index <= r_index;
`ifdef DUMP_CHECKSUM_EN
            r_sum       <= r_sum + reg_rdata;
`endif
            if (r_index == LAST_REG) begin
              r_state    <= S_RD_MEM;
              r_index    <= 8'd0;
              r_reg_addr <= 5'd0;
              r_mem_addr <= MEM_BASE;
            end else begin
              r_index    <= r_index + 8'd1;
              r_reg_addr <= 5'(r_index + 8'd1);
            end
          end
        end

        S_RD_MEM: begin
          if (w_can_cap) begin
            r_out_valid <= 1'b1;
            r_out_data  <= mem_rdata;
            r_out_kind  <= KIND_MEM;
            r_out_index <= r_index;
`ifdef DUMP_CHECKSUM_EN
            r_sum       <= r_sum + mem_rdata;
`endif
            if (r_index == LAST_MEM) begin
`ifdef DUMP_CHECKSUM_EN
              r_state <= S_SUM;
`else
              r_state <= S_FIN;
`endif
              r_index <= 8'd0;
            end else begin
              r_index    <= r_index + 8'd1;
              r_mem_addr <= r_mem_addr + 32'd4;
            end
          end
        end

`ifdef DUMP_CHECKSUM_EN
        S_SUM: begin
          if (w_can_cap) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_sum;
            r_out_kind  <= KIND_SUM;
            r_out_index <= 8'd0;
            r_state     <= S_FIN;
          end
        end
`endif

        // done is raised once the last word drains, then busy drops on the following edge.
        S_FIN: begin
          if (r_done) begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_can_cap) begin
            r_done <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign reg_addr  = r_reg_addr;
  assign mem_addr  = r_mem_addr;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_kind  = r_out_kind;
  assign out_index = r_out_index;

endmodule

// File: tb/tb_state_dump_unit.sv
// Directed bench for state_dump_unit: register/memory models, stream monitor and checkpoint table.
module tb_state_dump_unit;

`ifdef DUMP_CHECKSUM_EN
  localparam int NWORDS = 41;
`else
  localparam int NWORDS = 40;
`endif

  logic        clk = 1'b0;
  logic        rst, start, out_ready;
  logic        busy, done, out_valid;
  logic [4:0]  reg_addr;
  logic [31:0] reg_rdata, mem_addr, mem_rdata, out_data;
  logic [1:0]  out_kind;
  logic [7:0]  out_index;

  always #5 clk = ~clk;

  state_dump_unit #(.NREGS(32), .NMEMW(8), .MEM_BASE(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .reg_addr(reg_addr), .reg_rdata(reg_rdata),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_kind(out_kind), .out_index(out_index)
  );

  logic [31:0] regs [32];
  logic [31:0] mem  [64];

  assign reg_rdata = regs[reg_addr];
  assign mem_rdata = (mem_addr[31:8] == 24'd0 && mem_addr[1:0] == 2'd0) ? mem[mem_addr[7:2]]
                                                                        : 32'hBAD0_BAD0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: sole writer of the capture log and event counters.
  int          cyc = 0;
  int          rx_n = 0, done_cnt = 0, done_cyc = 0, stall_err = 0;
  logic [1:0]  rx_kind  [1024];
  logic [7:0]  rx_idx   [1024];
  logic [31:0] rx_data  [1024];
  logic [31:0] rx_maddr [1024];
  int          rx_cyc   [1024];
  logic        prev_stall = 1'b0;
  logic [31:0] h_data;
  logic [1:0]  h_kind;
  logic [7:0]  h_idx;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done && !rst) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (prev_stall && !rst &&
        (!out_valid || out_data !== h_data || out_kind !== h_kind || out_index !== h_idx))
      stall_err = stall_err + 1;
    prev_stall = out_valid && !out_ready && !rst;
    h_data = out_data;
    h_kind = out_kind;
    h_idx  = out_index;
    if (out_valid && out_ready && !rst && rx_n < 1024) begin
      rx_kind[rx_n]  = out_kind;
      rx_idx[rx_n]   = out_index;
      rx_data[rx_n]  = out_data;
      rx_maddr[rx_n] = mem_addr;
      rx_cyc[rx_n]   = cyc;
      rx_n = rx_n + 1;
    end
  end

  task automatic clear_models();
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
  endtask

  // Start a dump and wait for done; mode 1 toggles out_ready, poke re-pulses start mid-dump and on done.
  task automatic run_dump(input int mode, input bit poke, output int base, output int scyc,
                          output int d0, output bit ok);
    base = rx_n;
    d0   = done_cnt;
    ok   = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    scyc  = cyc;
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        ok = 1'b1;
        if (poke) start = 1'b1;
        break;
      end
      start = poke && (i == 5);
      out_ready = (mode == 1) ? ~out_ready : 1'b1;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    if (!ok) check("dump_timeout", 32'd0, 32'd1);
  endtask

  // Compare a logged dump against the expected order and model contents.
  task automatic verify_stream(input string name, input int base);
    int errs;
    logic [31:0] sum;
    errs = 0;
    sum  = 32'd0;
    for (int i = 0; i < NWORDS; i++) begin
      logic [1:0]  ek;
      logic [7:0]  ei;
      logic [31:0] ed;
      if (i < 32) begin
        ek = 2'b00; ei = 8'(i); ed = regs[i];
      end else if (i < 40) begin
        ek = 2'b01; ei = 8'(i - 32); ed = mem[i - 32];
      end else begin
        ek = 2'b10; ei = 8'd0; ed = sum;
      end
      sum = sum + ed;
      if (rx_kind[base+i] !== ek || rx_idx[base+i] !== ei || rx_data[base+i] !== ed) errs++;
    end
    check({name, "_count"}, 32'(rx_n - base), 32'(NWORDS));
    check({name, "_order"}, 32'(errs), 32'd0);
  endtask

  typedef struct {
    int          word;
    logic [1:0]  kind;
    logic [7:0]  idx;
    logic [31:0] data;
  } chk_t;

  chk_t tbl [6];

  initial begin
    int  base, scyc, d0, nk2;
    bit  ok;

    tbl[0].word = 0;  tbl[0].kind = 2'b00; tbl[0].idx = 8'd0;  tbl[0].data = 32'h0000_0000;
    tbl[1].word = 1;  tbl[1].kind = 2'b00; tbl[1].idx = 8'd1;  tbl[1].data = 32'h0000_0005;
    tbl[2].word = 30; tbl[2].kind = 2'b00; tbl[2].idx = 8'd30; tbl[2].data = 32'h0000_0000;
    tbl[3].word = 31; tbl[3].kind = 2'b00; tbl[3].idx = 8'd31; tbl[3].data = 32'hDEAD_BEEF;
    tbl[4].word = 32; tbl[4].kind = 2'b01; tbl[4].idx = 8'd0;  tbl[4].data = 32'h0000_0000;
    tbl[5].word = 39; tbl[5].kind = 2'b01; tbl[5].idx = 8'd7;  tbl[5].data = 32'h0000_0000;

    clear_models();
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_valid",     32'(out_valid), 32'd0);
    check("rst_data",      out_data,       32'd0);
    check("rst_kind_idx",  32'({out_kind, out_index}), 32'd0);
    check("rst_reg_addr",  32'(reg_addr),  32'd0);
    check("rst_mem_addr",  mem_addr,       32'h0000_0000);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic dump, ready held high
    regs[1] = 32'h0000_0005; regs[31] = 32'hDEAD_BEEF;
    run_dump(0, 1'b0, base, scyc, d0, ok);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t1_word%0d_kind", tbl[i].word), 32'(rx_kind[base+tbl[i].word]), 32'(tbl[i].kind));
      check($sformatf("t1_word%0d_idx",  tbl[i].word), 32'(rx_idx[base+tbl[i].word]),  32'(tbl[i].idx));
      check($sformatf("t1_word%0d_data", tbl[i].word), rx_data[base+tbl[i].word],       tbl[i].data);
    end
    verify_stream("t1", base);
    check("t1_first_latency", 32'(rx_cyc[base] - scyc), 32'd1);
    check("t1_back_to_back",  32'(rx_cyc[base+NWORDS-1] - rx_cyc[base]), 32'(NWORDS - 1));
    check("t1_done_latency",  32'(done_cyc - scyc), 32'(NWORDS + 1));
    check("t1_done_count",    32'(done_cnt - d0), 32'd1);
    check("t1_busy_after",    32'(busy), 32'd0);

    // Memory word 3 at byte 0x0C
    clear_models();
    mem[3] = 32'h1234_5678;
    run_dump(0, 1'b0, base, scyc, d0, ok);
    check("t2_mem3_kind", 32'(rx_kind[base+35]), 32'd1);
    check("t2_mem3_idx",  32'(rx_idx[base+35]),  32'd3);
    check("t2_mem3_data", rx_data[base+35],      32'h1234_5678);
    check("t2_mem3_addr", rx_maddr[base+34],     32'h0000_000C);
    verify_stream("t2", base);

    // Back-pressure: out_ready toggling
    clear_models();
    for (int i = 0; i < 32; i++) regs[i] = 32'hA000_0000 + 32'(i);
    for (int i = 0; i < 8; i++)  mem[i]  = 32'h5000_0000 + 32'(i * 7);
    d0 = stall_err;
    out_ready = 1'b0;
    begin
      int se0;
      se0 = stall_err;
      run_dump(1, 1'b0, base, scyc, d0, ok);
      check("t3_stall_stable", 32'(stall_err - se0), 32'd0);
    end
    verify_stream("t3", base);
    check("t3_done_count", 32'(done_cnt - d0), 32'd1);

    // Reset after 10 accepted words
    base = rx_n;
    d0   = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (rx_n - base >= 10) break;
    end
    check("t4_accepted_before_rst", 32'(rx_n - base), 32'd10);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t4_valid_after_rst", 32'(out_valid), 32'd0);
    check("t4_busy_after_rst",  32'(busy),      32'd0);
    rst = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("t4_no_done", 32'(done_cnt - d0), 32'd0);
    check("t4_idle_busy", 32'(busy), 32'd0);
    run_dump(0, 1'b0, base, scyc, d0, ok);
    check("t4_restart_idx0", 32'({rx_kind[base], rx_idx[base]}), 32'd0);
    verify_stream("t4", base);

    // start re-pulsed mid-dump and in the done cycle
    run_dump(0, 1'b1, base, scyc, d0, ok);
    repeat (20) @(posedge clk);
    #1;
    verify_stream("t5", base);
    check("t5_done_count", 32'(done_cnt - d0), 32'd1);
    check("t5_idle", 32'(busy), 32'd0);

`ifdef DUMP_CHECKSUM_EN
    clear_models();
    regs[1] = 32'd1; regs[2] = 32'd2; mem[0] = 32'hFFFF_FFFF;
    run_dump(0, 1'b0, base, scyc, d0, ok);
    check("t6_sum_kind", 32'(rx_kind[base+40]), 32'd2);
    check("t6_sum_idx",  32'(rx_idx[base+40]),  32'd0);
    check("t6_sum_data", rx_data[base+40],      32'h0000_0002);
    verify_stream("t6", base);
`else
    nk2 = 0;
    for (int i = 0; i < rx_n; i++) if (rx_kind[i] == 2'b10) nk2++;
    check("no_checksum_kind", 32'(nk2), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/state_dump_unit.md
Name: state_dump_unit

Overview:
- Sequential scanner downstream of the processor core.
- On a start pulse it walks the register file (x0..x31), then the first words of data memory.
- Each value is emitted as a tagged 32-bit word on a valid/ready stream for the bench or a host link.
- It replaces hierarchical peeking into processor internals with a synthesizable, handshaked result-extraction path.

Parameters:
- NREGS, 32, number of registers dumped, indices 0..NREGS-1, max 32.
- NMEMW, 8, number of 32-bit data-memory words dumped, 1..64.
- MEM_BASE, 32'h0000_0000, byte address of the first dumped memory word; must be 4-aligned.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- busy  out  1  high while a dump is in progress.
- done  out  1  one-cycle pulse after the final word is accepted.
- reg_addr  out  5  register-file read address.
- reg_rdata  in  32  register read data; combinational, valid in the same cycle as reg_addr.
- mem_addr  out  32  data-memory byte address for a word read.
- mem_rdata  in  32  little-endian word at mem_addr; combinational, valid in the same cycle.
- out_valid  out  1  out_data/out_kind/out_index are valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_data  out  32  dumped value.
- out_kind  out  2  2'b00 register, 2'b01 memory word, 2'b10 checksum (optional feature only).
- out_index  out  8  register number, or memory word index (0..NMEMW-1), or 0 for checksum.

Behaviour:
- Reset (synchronous): state=IDLE, busy=0, done=0, out_valid=0, out_data=0, out_kind=0, out_index=0, reg_addr=0, mem_addr=MEM_BASE, internal index=0.
- States: IDLE, RD_REG, RD_MEM, [SUM], FIN.
- IDLE: if start, go to RD_REG and set index=0 and busy=1. start is ignored in every other state.
- RD_REG:
  - reg_addr=index. When no word is held (out_valid=0, or a handshake occurs this cycle), capture reg_rdata into out_data, out_kind=00, out_index=index, out_valid=1 on the next edge.
  - Index increments per capture.
  - After capturing index NREGS-1: go to RD_MEM, index=0.
- RD_MEM: mem_addr=MEM_BASE+4*index; same capture rule with out_kind=01. After index NMEMW-1: go to SUM if the feature is enabled, else FIN.
- Output holding: while out_valid && !out_ready, out_data/out_kind/out_index stay stable and no new read is captured.
- Throughput: back-to-back captures give 1 word/cycle when out_ready is held high. The first word appears the cycle after start is accepted (latency 1).
- FIN: wait until the last word is accepted (out_valid=0 after handshake). Then pulse done=1 for exactly one cycle, drop busy, return to IDLE.
- x0 is dumped as read; no forcing to zero.
- Total words per dump: NREGS+NMEMW (+1 with checksum).
- Reset asserted mid-dump: abort immediately to the reset state; the partially delivered stream is discarded; no done pulse.
- start in the same cycle as done: ignored (FSM is not yet in IDLE).
- A new start in IDLE after a completed dump restarts from register 0.

Optional Feature:
- Macro: DUMP_CHECKSUM_EN.
- Defined:
  - A 32-bit running sum (mod 2^32) of every captured out_data, cleared on start and on reset.
  - State SUM emits one extra word: out_kind=10, out_index=0, out_data=sum; then FIN.
- Undefined: no accumulator and no SUM state; out_kind never equals 10; RD_MEM goes directly to FIN.

Test Plan:
1. Register file x1=0x0000_0005, x31=0xDEAD_BEEF, others 0; memory all 0; out_ready=1; start pulse -> 40 words on consecutive cycles. Word 1 is kind 00, idx 1, 0x5; word 31 is 0xDEADBEEF; done pulses 41 cycles after start.
2. Memory word at byte 0x0C = 0x1234_5678 -> memory word with kind 01, idx 3 carries 0x12345678; mem_addr=0x0000_000C when captured.
3. out_ready toggled 1/0 each cycle -> data stable during stall cycles; no word lost or duplicated; all 40 indices delivered in order.
4. rst asserted after 10 accepted words -> next cycle out_valid=0, busy=0; no done pulse. A following start restarts at reg idx 0.
5. start pulsed while busy, and again in the done cycle -> no effect; exactly one dump of 40 words.
6. With DUMP_CHECKSUM_EN, values x1=1, x2=2, mem[0]=0xFFFF_FFFF -> 41st word has kind 10, data 0x0000_0002 (wrap mod 2^32).
